// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit XNOR LFSR generator and checker.
// Holds the polynomial, lock-up value, checker state encoding and next-word function.
package lfsr_pkg;

  localparam int LFSR_W = 16;

  // Taps 16,15,13,4 -> bit positions 15,14,12,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hD008;

  // XNOR feedback never leaves this value once it is reached
  localparam logic [LFSR_W-1:0] LOCKUP_VAL = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEED   = 2'd1,
    ST_SEEDED = 2'd2,
    ST_LOCKED = 2'd3
  } chk_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] e
  );
    return {e[LFSR_W-2:0], ~^(e & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Ports: clock, rst, inc, clr in; count out (CNT_W bits).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 16-bit XNOR LFSR stream: self-syncs, flags misses, counts.
// Ports: clock, rst, en_chk, clr, data_in, data_valid in; locked, err_pulse, lockup, match_count, err_count out.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_THRESH = 4,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              en_chk,
  input  logic              clr,
  input  logic [LFSR_W-1:0] data_in,
  input  logic              data_valid,
  output logic              locked,
  output logic              err_pulse,
  output logic              lockup,
  output logic [CNT_W-1:0]  match_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [3:0] LOCK_T = 4'(LOCK_THRESH);
  localparam logic [3:0] LOSS_T = 4'(LOSS_THRESH);

  chk_state_e        state_q, state_d;
  logic [LFSR_W-1:0] exp_q, exp_d;
  logic [3:0]        run_q, run_d;
  logic [3:0]        miss_q, miss_d;
  logic              err_d, lkp_d;
  logic              m_inc, e_inc;
  logic [LFSR_W-1:0] pred;
  logic              hit, is_lkp;

  assign pred   = lfsr_next(exp_q);
  assign is_lkp = (data_in == LOCKUP_VAL);
  // A lock-up word is never a good match, even if the prediction is itself stuck
  assign hit    = (data_in == pred) && !is_lkp;

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      exp_q     <= '0;
      run_q     <= '0;
      miss_q    <= '0;
      err_pulse <= 1'b0;
      lockup    <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      run_q     <= run_d;
      miss_q    <= miss_d;
      err_pulse <= err_d;
      lockup    <= lkp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    run_d   = run_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    lkp_d   = 1'b0;
    m_inc   = 1'b0;
    e_inc   = 1'b0;
    if (!en_chk) begin
      state_d = ST_IDLE;
      exp_d   = '0;
      run_d   = '0;
      miss_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_SEED;
        ST_SEED: begin
          if (data_valid) begin
            exp_d   = data_in;
            run_d   = '0;
            miss_d  = '0;
            lkp_d   = is_lkp;
            state_d = ST_SEEDED;
          end
        end
        ST_SEEDED: begin
          if (data_valid) begin
            exp_d = data_in;
            lkp_d = is_lkp;
            if (hit) begin
              m_inc = 1'b1;
              if (run_q + 4'd1 == LOCK_T) begin
                run_d   = '0;
                state_d = ST_LOCKED;
              end else begin
                run_d = run_q + 4'd1;
              end
            end else begin
              err_d   = 1'b1;
              e_inc   = 1'b1;
              state_d = ST_SEED;
            end
          end
        end
        ST_LOCKED: begin
          if (data_valid) begin
            lkp_d = is_lkp;
            if (hit) begin
              m_inc  = 1'b1;
              miss_d = '0;
              exp_d  = data_in;
            end else begin
              // Flywheel: keep predicting, do not adopt the bad word
              err_d = 1'b1;
              e_inc = 1'b1;
              exp_d = pred;
              if (is_lkp || (miss_q + 4'd1 == LOSS_T)) begin
                miss_d  = '0;
                state_d = ST_SEED;
              end else begin
                miss_d = miss_q + 4'd1;
              end
            end
          end
        end
      endcase
    end
  end

  assign locked = (state_q == ST_LOCKED);

  sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
    .clock (clock),
    .rst   (rst),
    .inc   (m_inc),
    .clr   (clr),
    .count (match_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clock (clock),
    .rst   (rst),
    .inc   (e_inc),
    .clr   (clr),
    .count (err_count)
  );

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, flywheel, loss, lock-up,
// saturation (CNT_W=8), clr priority, en_chk drop and reset mid-lock.
module tb_lfsr_checker;

  logic        clock = 1'b0;
  logic        rst;
  logic        en_chk;
  logic        clr;
  logic [15:0] data_in;
  logic        data_valid;
  logic        locked;
  logic        err_pulse;
  logic        lockup;
  logic [7:0]  match_count;
  logic [7:0]  err_count;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] w;

  always #5 clock = ~clock;

  lfsr_checker #(
    .LOCK_THRESH (4),
    .LOSS_THRESH (3),
    .CNT_W       (8)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .en_chk      (en_chk),
    .clr         (clr),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .lockup      (lockup),
    .match_count (match_count),
    .err_count   (err_count)
  );

  function automatic logic [15:0] nx(input logic [15:0] e);
    logic fb;
    fb = ~(e[15] ^ e[14] ^ e[12] ^ e[3]);
    return {e[14:0], fb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // Present one word for one clock; returns on the following negedge.
  task automatic push(input logic [15:0] v);
    data_in    = v;
    data_valid = 1'b1;
    @(negedge clock);
    data_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clock);
  endtask

  // Seed with the next stream word, then four matching words.
  task automatic relock(input string tag);
    w = nx(w);
    push(w);
    chk({tag, "_seed_lk"}, 32'(locked), 32'd0);
    for (int i = 0; i < 3; i++) begin
      w = nx(w);
      push(w);
    end
    chk({tag, "_lk_3"}, 32'(locked), 32'd0);
    w = nx(w);
    push(w);
    chk({tag, "_lk_4"}, 32'(locked), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    en_chk     = 1'b0;
    clr        = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_errp", 32'(err_pulse), 32'd0);
    chk("rst_lockup", 32'(lockup), 32'd0);
    chk("rst_match", 32'(match_count), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);

    // Initial lock from seed 0005
    rst    = 1'b0;
    en_chk = 1'b1;
    idle();
    push(16'h0005);
    chk("seed_match", 32'(match_count), 32'd0);
    chk("seed_errp", 32'(err_pulse), 32'd0);
    push(16'h000B);
    push(16'h0016);
    push(16'h002D);
    chk("pre_lock", 32'(locked), 32'd0);
    chk("pre_lock_m", 32'(match_count), 32'd3);
    push(16'h005A);
    chk("lock", 32'(locked), 32'd1);
    chk("lock_match", 32'(match_count), 32'd4);
    chk("lock_err", 32'(err_count), 32'd0);

    // One bad word in LOCKED; prediction was 00B4, next 0169
    push(16'h1234);
    chk("inj_errp", 32'(err_pulse), 32'd1);
    chk("inj_err", 32'(err_count), 32'd1);
    chk("inj_locked", 32'(locked), 32'd1);
    chk("inj_match", 32'(match_count), 32'd4);
    push(16'h0169);
    chk("fly_errp", 32'(err_pulse), 32'd0);
    chk("fly_match", 32'(match_count), 32'd5);
    chk("fly_locked", 32'(locked), 32'd1);
    w = 16'h0169;

    // Clear, then three garbage words drop lock
    clr = 1'b1;
    idle();
    clr = 1'b0;
    chk("clr_match", 32'(match_count), 32'd0);
    chk("clr_err", 32'(err_count), 32'd0);
    push(16'h1111);
    push(16'h2222);
    chk("loss_2", 32'(locked), 32'd1);
    push(16'h3333);
    chk("loss_3", 32'(locked), 32'd0);
    chk("loss_err", 32'(err_count), 32'd3);
    chk("loss_errp", 32'(err_pulse), 32'd1);
    w = 16'h0001;
    relock("relock");
    chk("relock_m", 32'(match_count), 32'd4);

    // en_chk drop, then lock-up word while SEEDED
    en_chk = 1'b0;
    idle();
    chk("dis_locked", 32'(locked), 32'd0);
    chk("dis_match", 32'(match_count), 32'd4);
    chk("dis_err", 32'(err_count), 32'd3);
    en_chk = 1'b1;
    idle();
    push(16'h0005);
    push(16'h000B);
    chk("sd_match", 32'(match_count), 32'd5);
    push(16'hFFFF);
    chk("lkp_pulse", 32'(lockup), 32'd1);
    chk("lkp_errp", 32'(err_pulse), 32'd1);
    chk("lkp_err", 32'(err_count), 32'd4);
    chk("lkp_locked", 32'(locked), 32'd0);
    idle();
    chk("lkp_pulse_end", 32'(lockup), 32'd0);
    chk("lkp_errp_end", 32'(err_pulse), 32'd0);
    // In SEED: 0016 is a seed, not compared against next(FFFF)
    push(16'h0016);
    chk("reseed_errp", 32'(err_pulse), 32'd0);
    chk("reseed_err", 32'(err_count), 32'd4);
    push(16'h002D);
    push(16'h005A);
    push(16'h00B4);
    chk("lkp_rl_3", 32'(locked), 32'd0);
    push(16'h0169);
    chk("lkp_rl_4", 32'(locked), 32'd1);
    chk("lkp_rl_m", 32'(match_count), 32'd9);
    w = 16'h0169;

    // Saturation at 8'hFF
    for (int i = 0; i < 245; i++) begin
      w = nx(w);
      push(w);
    end
    chk("sat_fe", 32'(match_count), 32'hFE);
    w = nx(w);
    push(w);
    w = nx(w);
    push(w);
    chk("sat_ff", 32'(match_count), 32'hFF);
    w = nx(w);
    push(w);
    chk("sat_hold", 32'(match_count), 32'hFF);
    chk("sat_locked", 32'(locked), 32'd1);
    clr = 1'b1;
    w = nx(w);
    push(w);
    clr = 1'b0;
    chk("clr_win_m", 32'(match_count), 32'd0);
    chk("clr_win_e", 32'(err_count), 32'd0);

    // en_chk low mid-lock; valid word while disabled is ignored
    w = nx(w);
    push(w);
    w = nx(w);
    push(w);
    chk("pre_dis_m", 32'(match_count), 32'd2);
    en_chk = 1'b0;
    push(nx(w));
    chk("dis2_locked", 32'(locked), 32'd0);
    chk("dis2_match", 32'(match_count), 32'd2);
    chk("dis2_errp", 32'(err_pulse), 32'd0);
    en_chk = 1'b1;
    idle();
    relock("en");
    chk("en_rl_m", 32'(match_count), 32'd6);

    // Reset mid-lock
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("mrst_locked", 32'(locked), 32'd0);
    chk("mrst_match", 32'(match_count), 32'd0);
    chk("mrst_err", 32'(err_count), 32'd0);
    idle();
    relock("rst");
    chk("rst_rl_m", 32'(match_count), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
